ex_stage: RTL

Execute stage of the five-stage LoongArch-32 pipeline, between the decode stage and the memory stage. It registers the 163-bit decode bus and computes ALU, multiply and divide results. Divides run on an iterative 32-step divider. The stage also issues the data-SRAM request for loads and stores, and feeds destination and value forwarding back to decode.

---
 rtl/ex_stage_pkg.sv | 44 ++++
 rtl/ex_stage_div_unit.sv | 47 ++++
 rtl/ex_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: bus layouts, opcode bit indices and divider states for the execute stage
package ex_stage_pkg;
  localparam int DS_TO_ES_BUS_W = 163;
  localparam int ES_TO_MS_BUS_W = 78;
  localparam int LD_ST_OP_LSB = 155;
  localparam int MUL_DIV_OP_LSB = 148;
  localparam int PC_LSB = 116;
  localparam int ALU_OP_LSB = 104;
  localparam int SRC1_LSB = 72;
  localparam int SRC2_LSB = 40;
  localparam int RKD_LSB = 8;
  localparam int RES_FROM_MEM_BIT = 7;
  localparam int MEM_WE_BIT = 6;
  localparam int DEST_LSB = 1;
  localparam int GR_WE_BIT = 0;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_NOR = 5;
  localparam int ALU_OR = 6;
  localparam int ALU_XOR = 7;
  localparam int ALU_SLL = 8;
  localparam int ALU_SRL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_LUI = 11;
  localparam int OP_MUL_W = 0;
  localparam int OP_MULH_W = 1;
  localparam int OP_MULH_WU = 2;
  localparam int OP_DIV_W = 3;
  localparam int OP_MOD_W = 4;
  localparam int OP_DIV_WU = 5;
  localparam int OP_MOD_WU = 6;
  localparam int OP_LD_W = 0;
  localparam int OP_LD_HU = 1;
  localparam int OP_LD_H = 2;
  localparam int OP_LD_BU = 3;
  localparam int OP_LD_B = 4;
  localparam int OP_ST_W = 5;
  localparam int OP_ST_H = 6;
  localparam int OP_ST_B = 7;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/ex_stage_div_unit.sv
// div_unit: 32-step restoring divider producing signed or unsigned quotient and remainder
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_t state, state_nx;
  logic [4:0] cnt;
  logic [31:0] q, r, d;
  logic q_neg, r_neg, ge;
  logic [32:0] t;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? BUSY : IDLE) :
               state == BUSY ? (cnt == 5'd31 ? DONE : BUSY) :
               (ack ? IDLE : DONE);
  assign t = {r, q[31]};
  assign ge = t >= {1'b0, d};
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (state == IDLE && start) begin
      cnt <= '0;
      q <= sign && dividend[31] ? -dividend : dividend;
      d <= sign && divisor[31] ? -divisor : divisor;
      r <= '0;
      q_neg <= sign && (dividend[31] ^ divisor[31]) && |divisor;
      r_neg <= sign && dividend[31];
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      q <= {q[30:0], ge};
      r <= ge ? 32'(t - {1'b0, d}) : t[31:0];
    end
  assign done = state == DONE;
  assign quotient = q_neg ? -q : q;
  assign remainder = r_neg ? -r : r;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with inline ALU/multiplier, iterative divider, data-SRAM request and forwarding
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus,
  output logic                      es_allowin,
  input  logic                      ms_allowin,
  output logic                      es_to_ms_valid,
  output logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  output logic [4:0]                es_to_ds_dest,
  output logic [31:0]               es_to_ds_value,
  output logic                      es_value_from_mem,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata
);
  logic es_valid, es_ready_go, is_div, is_mul, div_done, res_from_mem, mem_we, gr_we;
  logic [DS_TO_ES_BUS_W-1:0] es_bus;
  logic [7:0] ld_st_op;
  logic [6:0] mul_div_op;
  logic [11:0] alu_op;
  logic [4:0] dest;
  logic [31:0] pc, src1, src2, rkd, alu_res, mul_res, quotient, remainder, result;
  logic signed [63:0] ma, mb, prod;
  always_ff @(posedge clk)
    if (reset) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  always_ff @(posedge clk)
    if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
  assign ld_st_op = es_bus[LD_ST_OP_LSB +: 8];
  assign mul_div_op = es_bus[MUL_DIV_OP_LSB +: 7];
  assign pc = es_bus[PC_LSB +: 32];
  assign alu_op = es_bus[ALU_OP_LSB +: 12];
  assign src1 = es_bus[SRC1_LSB +: 32];
  assign src2 = es_bus[SRC2_LSB +: 32];
  assign rkd = es_bus[RKD_LSB +: 32];
  assign res_from_mem = es_bus[RES_FROM_MEM_BIT];
  assign mem_we = es_bus[MEM_WE_BIT];
  assign dest = es_bus[DEST_LSB +: 5];
  assign gr_we = es_bus[GR_WE_BIT];
  assign alu_res = ({32{alu_op[ALU_ADD]}} & (src1 + src2))
                 | ({32{alu_op[ALU_SUB]}} & (src1 - src2))
                 | ({32{alu_op[ALU_SLT]}} & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[ALU_SLTU]}} & {31'd0, src1 < src2})
                 | ({32{alu_op[ALU_AND]}} & (src1 & src2))
                 | ({32{alu_op[ALU_NOR]}} & ~(src1 | src2))
                 | ({32{alu_op[ALU_OR]}} & (src1 | src2))
                 | ({32{alu_op[ALU_XOR]}} & (src1 ^ src2))
                 | ({32{alu_op[ALU_SLL]}} & (src1 << src2[4:0]))
                 | ({32{alu_op[ALU_SRL]}} & (src1 >> src2[4:0]))
                 | ({32{alu_op[ALU_SRA]}} & $unsigned($signed(src1) >>> src2[4:0]))
                 | ({32{alu_op[ALU_LUI]}} & src2);
  // 33x33 signed product: mulh_wu zero-extends, everything else sign-extends
  assign ma = {{32{~mul_div_op[OP_MULH_WU] & src1[31]}}, src1};
  assign mb = {{32{~mul_div_op[OP_MULH_WU] & src2[31]}}, src2};
  assign prod = ma * mb;
  assign mul_res = mul_div_op[OP_MUL_W] ? prod[31:0] : prod[63:32];
  assign is_mul = mul_div_op[OP_MUL_W] | mul_div_op[OP_MULH_W] | mul_div_op[OP_MULH_WU];
  assign is_div = mul_div_op[OP_DIV_W] | mul_div_op[OP_MOD_W] | mul_div_op[OP_DIV_WU] | mul_div_op[OP_MOD_WU];
  div_unit u_div (
    .clk(clk),
    .reset(reset),
    .start(es_valid && is_div),
    .ack(es_to_ms_valid && ms_allowin),
    .sign(mul_div_op[OP_DIV_W] | mul_div_op[OP_MOD_W]),
    .dividend(src1),
    .divisor(src2),
    .done(div_done),
    .quotient(quotient),
    .remainder(remainder)
  );
  assign result = is_div ? (mul_div_op[OP_DIV_W] | mul_div_op[OP_DIV_WU] ? quotient : remainder) :
                  is_mul ? mul_res : alu_res;
  assign es_ready_go = !is_div || div_done;
  assign es_allowin = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_to_ms_bus = {ld_st_op[OP_LD_B], ld_st_op[OP_LD_BU], ld_st_op[OP_LD_H], ld_st_op[OP_LD_HU],
                         ld_st_op[OP_LD_W], alu_res[1:0], pc, res_from_mem, gr_we, dest, result};
  assign es_to_ds_dest = es_valid && gr_we ? dest : 5'd0;
  assign es_to_ds_value = result;
  assign es_value_from_mem = es_valid && (res_from_mem || (is_div && !div_done));
  assign data_sram_en = es_valid && ms_allowin && (res_from_mem || mem_we);
  assign data_sram_addr = alu_res;
  assign data_sram_we = ld_st_op[OP_ST_W] ? 4'b1111 :
                        ld_st_op[OP_ST_H] ? (alu_res[1] ? 4'b1100 : 4'b0011) :
                        ld_st_op[OP_ST_B] ? 4'b0001 << alu_res[1:0] : 4'b0000;
  assign data_sram_wdata = ld_st_op[OP_ST_B] ? {4{rkd[7:0]}} :
                           ld_st_op[OP_ST_H] ? {2{rkd[15:0]}} : rkd;
endmodule
